regfile_mp_scoreboard: RTL and testbench
========================================

// Module: regfile_mp_scoreboard
// PURPOSE
//  Parametrised multi-port integer register file for the pipelined core. It is
//  the successor to the 2R1W register file: NRD read ports, two write-back
//  ports (ALU and LSU), optional write-to-read bypass, and a per-register
//  pending (scoreboard) bit that decode uses for RAW-hazard stalls.
//  Sits between decode (reads, issue) and write-back (writes).
// PARAMETERS
//  XLEN    32  data width of each register
//  NREGS   32  number of registers; AW = $clog2(NREGS)
//  NRD     2   number of read ports (1..4)
//  BYPASS  1   1: a same-cycle write is forwarded to reads; 0: no forwarding
// PORTS
//  clk          in   1         clock, all state updates on rising edge
//  reset        in   1         asynchronous, active-high reset
//  ra           in   NRD*AW    read addresses; port i = ra[i*AW +: AW]
//  rd           out  NRD*XLEN  read data; port i = rd[i*XLEN +: XLEN]
//  rbusy        out  NRD       pending bit of register addressed by port i
//  we0,wa0,wd0  in   1,AW,XLEN write port 0 (ALU write-back)
//  we1,wa1,wd1  in   1,AW,XLEN write port 1 (LSU write-back, higher priority)
//  issue_valid  in   1         instruction with destination issued this cycle
//  issue_rd     in   AW        destination register of issued instruction
//  pend_cnt     out  AW+1      number of registers currently pending
// BEHAVIOUR
//  - Reset (async, active-high): all registers = 0, all pending bits = 0.
//    rd = 0 for every address, rbusy = 0, pend_cnt = 0 while reset is high.
//    Reset asserted mid-operation discards any write or issue in that cycle.
//  - Register 0: reads always return 0; writes are ignored; it is never
//    pending (issue_rd = 0 has no effect); rbusy for address 0 is always 0.
//  - Reads are combinational from ra. Out-of-range addresses (>= NREGS)
//    read 0 with rbusy = 0.
//  - Writes: weK & waK != 0 updates reg[waK] = wdK on the rising edge.
//    If both ports write the same address, port 1's data is stored.
//  - Read latency: BYPASS=0 -> written value visible the cycle after the
//    edge. BYPASS=1 -> read of an address written this cycle returns the
//    incoming wd (wd1 if both ports hit), same cycle.
//  - Pending bits: issue_valid & issue_rd != 0 sets pend[issue_rd]; a write
//    on either port clears pend[waK]. Issue and write to the same address in
//    the same cycle: set wins (newer producer), data is still written.
//    Issue with pend already set keeps it set (no error, no double count).
//  - rbusy[i] = pend[ra_i]; with BYPASS=1 it is forced to 0 when a write to
//    ra_i occurs in the same cycle (value is being forwarded).
//  - pend_cnt equals the popcount of the pending vector after every edge;
//    it may drop by 2 in one cycle (two clears) or move +1/-1/-2 combined.
//    Range 0..NREGS-1; never wraps.
// TESTING
//  1. Reset, then read all addresses on all ports -> rd = 0, rbusy = 0,
//     pend_cnt = 0.
//  2. we0 wa0=0 wd0=DEADBEEF, then read x0 -> 0; pend_cnt stays 0 after
//     issue_rd=0.
//  3. we0 wa0=5 wd0=11112222 and we1 wa1=5 wd1=33334444 in one cycle ->
//     x5 = 33334444; with BYPASS=1, ra0=5 in that cycle reads 33334444.
//  4. issue_rd=7 -> next cycle rbusy=1 for ra=7, pend_cnt=1; we1 wa1=7
//     wd1=0000ABCD -> same cycle rbusy=0 (BYPASS=1), next cycle pend_cnt=0.
//  5. issue_rd=3 and we0 wa0=3 same cycle -> x3 written, pend[3] stays 1;
//     issue 8,9 then write 8 and 9 on both ports together -> pend_cnt 3->1.
//  6. BYPASS=0 build: write x2=CAFEF00D, read same cycle -> old value 0;
//     next cycle -> CAFEF00D. Assert reset mid-write -> x2 = 0, pend_cnt = 0.

Source files
------------

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port integer register file with NRD combinational read ports, two write-back
// ports (port 1 has priority), optional write-to-read forwarding and a per-register pending scoreboard.
module regfile_mp_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rbusy,
  input  logic                we0,
  input  logic [AW-1:0]       wa0,
  input  logic [XLEN-1:0]     wd0,
  input  logic                we1,
  input  logic [AW-1:0]       wa1,
  input  logic [XLEN-1:0]     wd1,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rd,
  output logic [AW:0]         pend_cnt
);

  localparam bit FULL = (NREGS == (1 << AW));

  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] pend;
  logic w0_hit, w1_hit, iss_hit;

  // Addresses beyond NREGS exist only when NREGS is not a power of two.
  function automatic logic in_range(input logic [AW-1:0] a);
    return FULL || (int'(a) < NREGS);
  endfunction

  assign w0_hit  = we0 && (wa0 != '0) && in_range(wa0);
  assign w1_hit  = we1 && (wa1 != '0) && in_range(wa1);
  assign iss_hit = issue_valid && (issue_rd != '0) && in_range(issue_rd);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      pend <= '0;
    end else begin
      if (w0_hit) regs[wa0] <= wd0;
      if (w1_hit) regs[wa1] <= wd1;
      // A new issue marks a newer producer, so set beats a same-cycle clear.
      for (int r = 1; r < NREGS; r++) begin
        if (iss_hit && (issue_rd == AW'(r)))
          pend[r] <= 1'b1;
        else if ((w0_hit && (wa0 == AW'(r))) || (w1_hit && (wa1 == AW'(r))))
          pend[r] <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rport
    logic [AW-1:0]   a;
    logic            hit0, hit1, busy;
    logic [XLEN-1:0] stored, data;

    assign a      = ra[i*AW +: AW];
    assign hit0   = w0_hit && (wa0 == a);
    assign hit1   = w1_hit && (wa1 == a);
    assign stored = ((a != '0) && in_range(a)) ? regs[a] : '0;

    always_comb begin
      data = stored;
      busy = in_range(a) && pend[a];
      if (BYPASS != 0) begin
        if (hit1)      data = wd1;
        else if (hit0) data = wd0;
        if (hit0 || hit1) busy = 1'b0;
      end
      if (reset) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign rd[i*XLEN +: XLEN] = data;
    assign rbusy[i]           = busy;
  end

  always_comb begin
    pend_cnt = '0;
    for (int r = 0; r < NREGS; r++) pend_cnt = pend_cnt + (AW+1)'(pend[r]);
  end

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Directed bench: a forwarding 32-entry build and a non-forwarding 24-entry build
// share one stimulus stream; each step checks both against hand-computed values.
module tb_regfile_mp_scoreboard;

  localparam int AW = 5;

  logic        clk, reset;
  logic [9:0]  ra;
  logic        we0, we1, issue_valid;
  logic [4:0]  wa0, wa1, issue_rd;
  logic [31:0] wd0, wd1;
  logic [63:0] rd_b1, rd_b0;
  logic [1:0]  rbusy_b1, rbusy_b0;
  logic [5:0]  pc_b1, pc_b0;

  int total = 0;
  int bad   = 0;

  regfile_mp_scoreboard #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) u_b1 (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd_b1), .rbusy(rbusy_b1),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .pend_cnt(pc_b1)
  );

  regfile_mp_scoreboard #(.XLEN(32), .NREGS(24), .NRD(2), .BYPASS(0)) u_b0 (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd_b0), .rbusy(rbusy_b0),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .pend_cnt(pc_b0)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic clr_in();
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    issue_valid = 1'b0; issue_rd = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    ra    = '0;
    clr_in();
    #3;
    // outputs held at zero while reset is high, even with a forwarding write
    we1 = 1'b1; wa1 = 5'd5; wd1 = 32'hFFFF_FFFF; ra = {5'd5, 5'd5};
    #1;
    chk("rst_fwd_rd_b1", rd_b1, 64'h0);
    chk("rst_fwd_busy_b1", 64'(rbusy_b1), 64'h0);
    chk("rst_pc_b1", 64'(pc_b1), 64'h0);
    chk("rst_pc_b0", 64'(pc_b0), 64'h0);
    clr_in();
    cyc();
    reset = 1'b0;
    cyc();

    // 1: every address reads zero and idle
    for (int a = 0; a < 32; a++) begin
      ra = {5'(a), 5'(a)};
      #1;
      chk("init_rd_b1", rd_b1, 64'h0);
      chk("init_rd_b0", rd_b0, 64'h0);
      chk("init_busy", 64'({rbusy_b1, rbusy_b0}), 64'h0);
    end
    chk("init_pc_b1", 64'(pc_b1), 64'h0);
    chk("init_pc_b0", 64'(pc_b0), 64'h0);

    // 2: x0 is hardwired and never pending
    ra = {5'd0, 5'd0};
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hDEAD_BEEF;
    issue_valid = 1'b1; issue_rd = 5'd0;
    #1;
    chk("x0_same_b1", rd_b1, 64'h0);
    cyc();
    clr_in();
    chk("x0_rd_b1", rd_b1, 64'h0);
    chk("x0_rd_b0", rd_b0, 64'h0);
    chk("x0_pc_b1", 64'(pc_b1), 64'h0);
    chk("x0_pc_b0", 64'(pc_b0), 64'h0);

    // 3: both ports write x5, port 1 wins; forwarded only in the bypass build
    ra = {5'd5, 5'd5};
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h1111_2222;
    we1 = 1'b1; wa1 = 5'd5; wd1 = 32'h3333_4444;
    #1;
    chk("x5_fwd_b1", rd_b1, 64'h3333_4444_3333_4444);
    chk("x5_old_b0", rd_b0, 64'h0);
    cyc();
    clr_in();
    chk("x5_b1", rd_b1, 64'h3333_4444_3333_4444);
    chk("x5_b0", rd_b0, 64'h3333_4444_3333_4444);

    // 4: issue x7, then write it back on port 1
    issue_valid = 1'b1; issue_rd = 5'd7;
    cyc();
    clr_in();
    ra = {5'd0, 5'd7};
    #1;
    chk("p7_busy_b1", 64'(rbusy_b1), 64'h1);
    chk("p7_busy_b0", 64'(rbusy_b0), 64'h1);
    chk("p7_pc_b1", 64'(pc_b1), 64'h1);
    chk("p7_pc_b0", 64'(pc_b0), 64'h1);
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h0000_ABCD;
    #1;
    chk("w7_busy_b1", 64'(rbusy_b1), 64'h0);
    chk("w7_rd_b1", rd_b1, 64'h0000_ABCD);
    chk("w7_busy_b0", 64'(rbusy_b0), 64'h1);
    chk("w7_rd_b0", rd_b0, 64'h0);
    cyc();
    clr_in();
    chk("w7_pc_b1", 64'(pc_b1), 64'h0);
    chk("w7_pc_b0", 64'(pc_b0), 64'h0);
    chk("w7_after_b0", rd_b0, 64'h0000_ABCD);

    // 5: issue and write to x3 together -> data lands, pending stays set
    issue_valid = 1'b1; issue_rd = 5'd3;
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h0000_0033;
    cyc();
    clr_in();
    ra = {5'd0, 5'd3};
    #1;
    chk("x3_rd_b1", rd_b1, 64'h33);
    chk("x3_busy_b1", 64'(rbusy_b1), 64'h1);
    chk("x3_busy_b0", 64'(rbusy_b0), 64'h1);
    chk("x3_pc_b0", 64'(pc_b0), 64'h1);
    issue_valid = 1'b1; issue_rd = 5'd8;
    cyc();
    issue_rd = 5'd9;
    cyc();
    clr_in();
    chk("p89_pc_b1", 64'(pc_b1), 64'h3);
    chk("p89_pc_b0", 64'(pc_b0), 64'h3);
    ra = {5'd9, 5'd8};
    we0 = 1'b1; wa0 = 5'd8; wd0 = 32'h0000_0088;
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h0000_0099;
    #1;
    chk("w89_busy_b1", 64'(rbusy_b1), 64'h0);
    chk("w89_busy_b0", 64'(rbusy_b0), 64'h3);
    chk("w89_fwd_b1", rd_b1, 64'h0000_0099_0000_0088);
    cyc();
    clr_in();
    chk("w89_pc_b1", 64'(pc_b1), 64'h1);
    chk("w89_pc_b0", 64'(pc_b0), 64'h1);
    chk("w89_rd_b0", rd_b0, 64'h0000_0099_0000_0088);
    // clear x3 while issuing x10: count unchanged
    issue_valid = 1'b1; issue_rd = 5'd10;
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h0000_0333;
    cyc();
    clr_in();
    ra = {5'd10, 5'd3};
    #1;
    chk("swap_pc_b1", 64'(pc_b1), 64'h1);
    chk("swap_busy_b0", 64'(rbusy_b0), 64'h2);
    chk("swap_rd_b0", rd_b0[31:0], 64'h333);

    // out-of-range x30 exists only in the 32-entry build; re-issuing x10 is idempotent
    issue_valid = 1'b1; issue_rd = 5'd30;
    we0 = 1'b1; wa0 = 5'd30; wd0 = 32'h0000_0055;
    cyc();
    issue_rd = 5'd10;
    clr_in();
    issue_valid = 1'b1; issue_rd = 5'd10;
    cyc();
    clr_in();
    ra = {5'd10, 5'd30};
    #1;
    chk("oor_rd_b1", rd_b1[31:0], 64'h55);
    chk("oor_rd_b0", rd_b0[31:0], 64'h0);
    chk("oor_busy_b1", 64'(rbusy_b1), 64'h3);
    chk("oor_busy_b0", 64'(rbusy_b0), 64'h2);
    chk("oor_pc_b1", 64'(pc_b1), 64'h2);
    chk("oor_pc_b0", 64'(pc_b0), 64'h1);

    // 6: non-forwarding read latency on x2
    ra = {5'd2, 5'd0};
    we0 = 1'b1; wa0 = 5'd2; wd0 = 32'hCAFE_F00D;
    #1;
    chk("x2_same_b0", rd_b0[63:32], 64'h0);
    chk("x2_same_b1", rd_b1[63:32], 64'hCAFE_F00D);
    cyc();
    clr_in();
    chk("x2_next_b0", rd_b0[63:32], 64'hCAFE_F00D);

    // reset asserted during a write and an issue discards both
    we0 = 1'b1; wa0 = 5'd2; wd0 = 32'h1234_5678;
    issue_valid = 1'b1; issue_rd = 5'd4;
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rd_b1", rd_b1, 64'h0);
    chk("mid_rd_b0", rd_b0, 64'h0);
    chk("mid_pc", 64'({pc_b1, pc_b0}), 64'h0);
    cyc();
    reset = 1'b0;
    clr_in();
    #1;
    chk("post_x2_b1", rd_b1[63:32], 64'h0);
    chk("post_x2_b0", rd_b0[63:32], 64'h0);
    chk("post_pc_b1", 64'(pc_b1), 64'h0);
    chk("post_pc_b0", 64'(pc_b0), 64'h0);
    ra = {5'd5, 5'd4};
    #1;
    chk("post_x5_b1", rd_b1, 64'h0);
    chk("post_busy", 64'({rbusy_b1, rbusy_b0}), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
